bus_arbiter8: RTL and testbench

BUS_ARBITER8 -- requirements
Module: bus_arbiter8

---
 rtl/bus_arbiter8.sv | 112 +++++++++++
 tb/tb_bus_arbiter8.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter8.sv
// Eight-requester round-robin bus arbiter with a per-grant hold limit.
// Drives a 3-to-8 decoder through sel/en and also provides the decoded one-hot grant.
module bus_arbiter8 #(
   parameter int MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] sel,
   output logic       en,
   output logic [7:0] gnt,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state, state_n;
   logic [2:0] ptr, ptr_n;
   logic [7:0] cnt, cnt_n;
   logic [2:0] sel_n;
   logic       en_n;
   logic       timeout_n;

   logic       found;
   logic [2:0] win;
   logic [2:0] idx;

   // First set request bit at or above ptr, wrapping from 7 back to 0.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = ptr;
      for (int i = 0; i < 8; i++) begin
         idx = ptr + 3'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = cnt;
      sel_n     = sel;
      en_n      = en;
      timeout_n = 1'b0;
      case (state)
         IDLE, RELEASE: begin
            if (found) begin
               state_n = GRANT;
               sel_n   = win;
               en_n    = 1'b1;
               cnt_n   = 8'd0;
            end else begin
               state_n = IDLE;
               en_n    = 1'b0;
            end
         end
         GRANT: begin
            // A voluntary release outranks the hold limit, so timeout is only
            // flagged when the owner still wants the bus.
            if (done || !req[sel]) begin
               state_n = RELEASE;
               en_n    = 1'b0;
               ptr_n   = sel + 3'd1;
            end else if (cnt == HOLD_LAST) begin
               state_n   = RELEASE;
               en_n      = 1'b0;
               ptr_n     = sel + 3'd1;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            en_n    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= 3'd0;
         cnt     <= 8'd0;
         sel     <= 3'd0;
         en      <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         sel     <= sel_n;
         en      <= en_n;
         timeout <= timeout_n;
      end
   end

   // Decoded purely from registers so reset clears it without a clock edge.
   assign gnt = en ? (8'b0000_0001 << sel) : 8'h00;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed testbench for bus_arbiter8 with a hold limit of 4 cycles.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus_arbiter8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [2:0] sel;
   logic       en;
   logic [7:0] gnt;
   logic       timeout;

   int testCount;
   int failCount;

   bus_arbiter8 #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .en      (en),
      .gnt     (gnt),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [7:0] r, input logic d);
      req  = r;
      done = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      nextCycle();
      nextCycle();
      rst = 1'b0;
   endtask

   // Safety net in case the stimulus sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      testCount = 0;
      failCount = 0;
      rst = 1'b1;
      applyStimulus(8'h00, 1'b0);
      nextCycle();
      nextCycle();
      checkOutput("reset_en", en, 0);
      checkOutput("reset_gnt", gnt, 8'h00);
      checkOutput("reset_sel", sel, 0);
      checkOutput("reset_timeout", timeout, 0);
      rst = 1'b0;

      nextCycle();
      checkOutput("idle_no_req_en", en, 0);

      // Single requester granted one edge after requesting.
      applyStimulus(8'h04, 1'b0);
      nextCycle();
      checkOutput("req2_sel", sel, 2);
      checkOutput("req2_en", en, 1);
      checkOutput("req2_gnt", gnt, 8'h04);
      applyStimulus(8'h04, 1'b1);
      nextCycle();
      checkOutput("req2_release_en", en, 0);
      checkOutput("req2_release_to", timeout, 0);
      applyStimulus(8'h00, 1'b0);
      nextCycle();
      checkOutput("req2_idle_en", en, 0);

      // Full rotation with every requester active.
      pulseReset();
      applyStimulus(8'hFF, 1'b0);
      nextCycle();
      checkOutput("rr_first_sel", sel, 0);
      checkOutput("rr_first_en", en, 1);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(8'hFF, 1'b1);
         nextCycle();
         checkOutput($sformatf("rr_gap_en_%0d", k), en, 0);
         checkOutput($sformatf("rr_gap_to_%0d", k), timeout, 0);
         applyStimulus(8'hFF, 1'b0);
         nextCycle();
         checkOutput($sformatf("rr_sel_%0d", k), sel, k % 8);
         checkOutput($sformatf("rr_en_%0d", k), en, 1);
         checkOutput($sformatf("rr_gnt_%0d", k), gnt, 8'h01 << (k % 8));
      end
      applyStimulus(8'hFF, 1'b1);
      nextCycle();
      applyStimulus(8'h00, 1'b0);
      nextCycle();
      checkOutput("rr_idle_en", en, 0);

      // Lone requester 5 hits the hold limit and is granted again.
      applyStimulus(8'h20, 1'b0);
      nextCycle();
      checkOutput("hold_sel", sel, 5);
      for (int c = 1; c <= 4; c++) begin
         checkOutput($sformatf("hold_en_%0d", c), en, 1);
         checkOutput($sformatf("hold_to_%0d", c), timeout, 0);
         nextCycle();
      end
      checkOutput("hold_expire_en", en, 0);
      checkOutput("hold_expire_to", timeout, 1);
      nextCycle();
      checkOutput("hold_regrant_en", en, 1);
      checkOutput("hold_regrant_sel", sel, 5);
      checkOutput("hold_regrant_to", timeout, 0);

      // done arriving in the last allowed cycle suppresses the timeout flag.
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("lastcyc_en", en, 1);
      applyStimulus(8'h20, 1'b1);
      nextCycle();
      checkOutput("lastcyc_exit_en", en, 0);
      checkOutput("lastcyc_exit_to", timeout, 0);
      applyStimulus(8'h00, 1'b0);
      nextCycle();
      checkOutput("lastcyc_idle_to", timeout, 0);

      // Owner 6 releases; the pointer wraps past 7 to reach requester 0.
      applyStimulus(8'h40, 1'b0);
      nextCycle();
      checkOutput("wrap_own6_sel", sel, 6);
      applyStimulus(8'h09, 1'b1);
      nextCycle();
      checkOutput("wrap_release_en", en, 0);
      applyStimulus(8'h09, 1'b0);
      nextCycle();
      checkOutput("wrap_sel", sel, 0);
      checkOutput("wrap_gnt", gnt, 8'h01);

      // Mid-cycle reset during a grant of requester 3.
      applyStimulus(8'h08, 1'b1);
      nextCycle();
      applyStimulus(8'h08, 1'b0);
      nextCycle();
      checkOutput("rst_own3_sel", sel, 3);
      checkOutput("rst_own3_en", en, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_en", en, 0);
      checkOutput("rst_async_gnt", gnt, 8'h00);
      checkOutput("rst_async_to", timeout, 0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(8'h80, 1'b0);
      nextCycle();
      checkOutput("rst_after_sel", sel, 7);
      checkOutput("rst_after_en", en, 1);
      checkOutput("rst_after_gnt", gnt, 8'h80);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
